unified_mem_ctrl: RTL and testbench

- Parametrised successor to the shared instruction/data memory. One word array serves an instruction-fetch port and a load/store data port.
- Adds over the previous generation:
  - configurable width and depth
  - byte-enable stores
  - registered 1-cycle reads with valid/err handshake
  - alignment and range checking
  - write-first forwarding to fetch
  - sequential post-reset clear sweep replacing the all-at-once reset loop
- Sits between the core's PC/fetch stage and its LOAD/STORE stage.

---
 rtl/unified_mem_ctrl_if.sv | 35 +++
 rtl/unified_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_unified_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_ctrl_if.sv
// Fetch and load/store request/response bundle shared by the core and the
// unified word memory.
interface unified_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_valid;
    logic                  if_err;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_valid;
    logic                  d_err;

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid, if_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_valid, d_err
    );

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid, if_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_valid, d_err
    );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Shared instruction/data word memory: fetch port plus load/store port with
// byte enables, registered 1-cycle responses and a post-reset zero sweep.
module unified_mem_ctrl #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    unified_mem_ctrl_if.slave  bus
);
    localparam int          BYTES = DATA_W / 8;
    localparam int          OFF_W = $clog2(BYTES);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    // Range check is done on the full byte address so nothing aliases back into the array.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        logic [63:0] a;
        a = 64'(addr);
        return ((a & 64'(BYTES - 1)) != 64'd0) || (a >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'(64'(addr) >> OFF_W);
    endfunction

    function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BYTES-1:0]  be);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int k = 0; k < BYTES; k++) begin
            if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
        end
        return m;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic [IDX_W-1:0]  w_clr_cnt_nxt;

    logic              r_if_vld_p1;
    logic              r_if_err_p1;
    logic [DATA_W-1:0] r_if_rdata_p1;
    logic              r_d_vld_p1;
    logic              r_d_err_p1;
    logic [DATA_W-1:0] r_d_rdata_p1;

    logic              w_run;
    logic              w_if_fire;
    logic              w_d_fire;
    logic              w_if_bad;
    logic              w_d_bad;
    logic              w_store_ok;
    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_d_idx;
    logic [DATA_W-1:0] w_d_old;
    logic [DATA_W-1:0] w_d_merged;
    logic [DATA_W-1:0] w_d_word;
    logic [DATA_W-1:0] w_if_word;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_run      = (r_state == S_RUN);
    assign w_if_fire  = w_run & bus.if_req;
    assign w_d_fire   = w_run & bus.d_req;
    assign w_if_bad   = addr_bad(bus.if_addr);
    assign w_d_bad    = addr_bad(bus.d_addr);
    assign w_if_idx   = addr_idx(bus.if_addr);
    assign w_d_idx    = addr_idx(bus.d_addr);
    assign w_store_ok = w_d_fire & bus.d_we & ~w_d_bad;

    assign w_d_old    = r_mem[w_d_idx];
    assign w_d_merged = merge_be(w_d_old, bus.d_wdata, bus.d_be);
    assign w_d_word   = bus.d_we ? w_d_merged : w_d_old;

    // Write-first: a fetch hitting the word being stored sees the merged value.
    assign w_if_word  = (w_store_ok && (w_if_idx == w_d_idx)) ? w_d_merged : r_mem[w_if_idx];

    // Array writes are gated by rst so an asserted reset never disturbs contents.
    assign w_mem_we    = rst & ((r_state == S_CLEAR) | w_store_ok);
    assign w_mem_idx   = w_run ? w_d_idx : r_clr_cnt;
    assign w_mem_wdata = w_run ? w_d_merged : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        if (r_state == S_CLEAR) begin
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = S_RUN;
        end
    end

    // Stage p0 -> p1: request decode registered into the response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RST_STATE;
            r_clr_cnt     <= '0;
            r_if_vld_p1   <= 1'b0;
            r_if_err_p1   <= 1'b0;
            r_if_rdata_p1 <= '0;
            r_d_vld_p1    <= 1'b0;
            r_d_err_p1    <= 1'b0;
            r_d_rdata_p1  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_if_vld_p1 <= w_if_fire;
            r_if_err_p1 <= w_if_fire & w_if_bad;
            r_d_vld_p1  <= w_d_fire;
            r_d_err_p1  <= w_d_fire & w_d_bad;
            if (w_if_fire) r_if_rdata_p1 <= w_if_bad ? '0 : w_if_word;
            if (w_d_fire)  r_d_rdata_p1  <= w_d_bad ? '0 : w_d_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
    end

    assign ready        = w_run;
    assign bus.if_valid = r_if_vld_p1;
    assign bus.if_err   = r_if_err_p1;
    assign bus.if_rdata = r_if_rdata_p1;
    assign bus.d_valid  = r_d_vld_p1;
    assign bus.d_err    = r_d_err_p1;
    assign bus.d_rdata  = r_d_rdata_p1;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: reset/clear sweep, directed vector table,
// randomized traffic against a byte-level reference model, mid-sweep reset.
module tb_unified_mem_ctrl;
    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int AW  = 32;
    localparam int BYTES_TOTAL = DEP * DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready;

    unified_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    unified_mem_ctrl #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst_n), .ready(ready), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  be;
        logic [31:0] daddr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        r;
        logic [31:0] x_ir;
        logic        x_ie;
        logic [31:0] x_dr;
        logic        x_de;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [DEP];
    logic        e_ifv, e_ife, e_dv, e_de;
    logic [31:0] e_ir = 32'h0;
    logic [31:0] e_dr = 32'h0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t V(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [3:0] be,
                               input logic [31:0] daddr, input logic [31:0] wdata,
                               input logic [31:0] x_ir, input logic x_ie,
                               input logic [31:0] x_dr, input logic x_de);
        vec_t v;
        v.r = '{ireq, iaddr, dreq, dwe, be, daddr, wdata};
        v.x_ir = x_ir; v.x_ie = x_ie; v.x_dr = x_dr; v.x_de = x_de;
        return v;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= BYTES_TOTAL);
    endfunction

    // Reference: a store lands first, then the fetch reads (write-first).
    task automatic model_step(input req_t r);
        int wi;
        e_ifv = r.ireq; e_dv = r.dreq; e_ife = 1'b0; e_de = 1'b0;
        if (r.dreq) begin
            if (bad_addr(r.daddr)) begin
                e_de = 1'b1; e_dr = 32'h0;
            end else begin
                wi = int'(r.daddr / 4);
                if (r.dwe)
                    for (int b = 0; b < 4; b++)
                        if (r.be[b]) mdl[wi][8*b +: 8] = r.wdata[8*b +: 8];
                e_dr = mdl[wi];
            end
        end
        if (r.ireq) begin
            if (bad_addr(r.iaddr)) begin
                e_ife = 1'b1; e_ir = 32'h0;
            end else begin
                e_ir = mdl[int'(r.iaddr / 4)];
            end
        end
    endtask

    task automatic idle_bus();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic apply(input req_t r);
        @(negedge clk);
        bus.if_req = r.ireq; bus.if_addr = r.iaddr;
        bus.d_req = r.dreq; bus.d_we = r.dwe; bus.d_be = r.be;
        bus.d_addr = r.daddr; bus.d_wdata = r.wdata;
        model_step(r);
        @(posedge clk); #1;
        check1("if_valid", bus.if_valid, e_ifv);
        check1("if_err", bus.if_err, e_ife);
        check32("if_rdata", bus.if_rdata, e_ir);
        check1("d_valid", bus.d_valid, e_dv);
        check1("d_err", bus.d_err, e_de);
        check32("d_rdata", bus.d_rdata, e_dr);
        idle_bus();
    endtask

    // Counts edges until ready rises, noting any response pulse meanwhile.
    task automatic wait_ready(output int cnt, output logic saw_vld);
        logic done;
        cnt = 0; saw_vld = 1'b0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.if_valid || bus.d_valid) saw_vld = 1'b1;
            if (ready) done = 1'b1;
        end
        idle_bus();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            1:       a = 32'(BYTES_TOTAL + $urandom_range(0, 63) * 4);
            2:       a = $urandom & 32'hFFFF_FFFC;
            3, 4, 5: a = 32'($urandom_range(0, 7) * 4);
            default: a = 32'($urandom_range(0, 63) * 4);
        endcase
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[$];
        req_t r;
        int   cnt;
        logic saw;

        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_ready", ready, 1'b0);
        check1("rst_if_valid", bus.if_valid, 1'b0);
        check1("rst_d_valid", bus.d_valid, 1'b0);
        check1("rst_if_err", bus.if_err, 1'b0);
        check1("rst_d_err", bus.d_err, 1'b0);
        check32("rst_if_rdata", bus.if_rdata, 32'h0);
        check32("rst_d_rdata", bus.d_rdata, 32'h0);

        // Requests during the sweep must be ignored (no pulse, no write).
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'h10; bus.d_wdata = 32'hA5A5_5A5A;
        rst_n = 1'b1;
        wait_ready(cnt, saw);
        check32("clear_cycles", 32'(cnt), 32'd64);
        check1("clear_no_valid", saw, 1'b0);
        for (int i = 0; i < DEP; i++) mdl[i] = 32'h0;

        tab.push_back(V(1, 32'h00, 0, 0, 4'h0, 32'h00, 32'h0,        32'h0,         0, 32'h0,         0));
        tab.push_back(V(1, 32'hFC, 1, 0, 4'h0, 32'h10, 32'h0,        32'h0,         0, 32'h0,         0));
        tab.push_back(V(0, 32'h00, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,         0, 32'hDEADBEEF,  0));
        tab.push_back(V(0, 32'h00, 1, 0, 4'h0, 32'h10, 32'h0,        32'h0,         0, 32'hDEADBEEF,  0));
        tab.push_back(V(0, 32'h00, 1, 1, 4'h2, 32'h10, 32'h0000AA00, 32'h0,         0, 32'hDEADAAEF,  0));
        tab.push_back(V(0, 32'h00, 1, 0, 4'h0, 32'h10, 32'h0,        32'h0,         0, 32'hDEADAAEF,  0));
        tab.push_back(V(1, 32'h10, 1, 1, 4'hF, 32'h10, 32'h12345678, 32'h12345678,  0, 32'h12345678,  0));
        tab.push_back(V(0, 32'h00, 1, 0, 4'h0, 32'h13, 32'h0,        32'h0,         0, 32'h0,         1));
        tab.push_back(V(0, 32'h00, 1, 1, 4'hF, 32'h100, 32'hFFFFFFFF, 32'h0,        0, 32'h0,         1));
        tab.push_back(V(1, 32'h00, 1, 0, 4'h0, 32'h00, 32'h0,        32'h0,         0, 32'h0,         0));
        tab.push_back(V(1, 32'h102, 0, 0, 4'h0, 32'h00, 32'h0,       32'h0,         1, 32'h0,         0));
        tab.push_back(V(0, 32'h00, 1, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0,         0, 32'h0,         0));
        tab.push_back(V(1, 32'h20, 1, 0, 4'h0, 32'h10, 32'h0,        32'h0,         0, 32'h12345678,  0));
        tab.push_back(V(1, 32'h3FC, 1, 1, 4'h5, 32'h24, 32'h11223344, 32'h0,        1, 32'h00220044,  0));

        foreach (tab[i]) begin
            apply(tab[i].r);
            if (tab[i].r.ireq) begin
                check32($sformatf("vec%0d_if_rdata", i), bus.if_rdata, tab[i].x_ir);
                check1($sformatf("vec%0d_if_err", i), bus.if_err, tab[i].x_ie);
            end
            if (tab[i].r.dreq) begin
                check32($sformatf("vec%0d_d_rdata", i), bus.d_rdata, tab[i].x_dr);
                check1($sformatf("vec%0d_d_err", i), bus.d_err, tab[i].x_de);
            end
        end

        for (int n = 0; n < 400; n++) begin
            r.ireq  = 1'($urandom_range(0, 1));
            r.dreq  = 1'($urandom_range(0, 1));
            r.dwe   = 1'($urandom_range(0, 1));
            r.be    = 4'($urandom);
            r.daddr = rand_addr();
            r.iaddr = ($urandom_range(0, 3) == 0) ? r.daddr : rand_addr();
            r.wdata = $urandom;
            apply(r);
        end

        // An in-flight response is dropped by an asynchronous reset.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h4; bus.d_req = 1'b1; bus.d_addr = 32'h8;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check1("inflight_if_valid", bus.if_valid, 1'b0);
        check1("inflight_d_valid", bus.d_valid, 1'b0);
        check1("inflight_ready", ready, 1'b0);

        // Abort the sweep at clear cycle 20 with a fetch held the whole time.
        @(negedge clk);
        bus.if_addr = 32'h10;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.if_valid || bus.d_valid) saw = 1'b1;
        end
        #1 rst_n = 1'b0;
        #1;
        check1("abort_ready", ready, 1'b0);
        check1("abort_no_valid", saw, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.if_req = 1'b1;
        rst_n = 1'b1;
        wait_ready(cnt, saw);
        check32("reclear_cycles", 32'(cnt), 32'd64);
        check1("reclear_no_valid", saw, 1'b0);
        for (int i = 0; i < DEP; i++) mdl[i] = 32'h0;

        for (int i = 0; i < DEP; i++) begin
            r = '{1'b1, 32'(i * 4), 1'b1, 1'b0, 4'h0, 32'((DEP - 1 - i) * 4), 32'h0};
            apply(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
